// File: rtl/tboom_freelist_pkg.sv
// ============================================================================
// Module : tboom_freelist_pkg
// Brief  : Shared sizing helpers for the TinyBOOM rename free-list buffer.
//          ptr_w() gives the pointer width for a given depth: index bits plus
//          one wrap bit. The wrap bit lets the full (count == depth) and
//          empty (count == 0) conditions be told apart.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tboom_freelist_pkg;

    // Pointer width for a ring of `depth` entries (index bits + wrap bit).
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Default configuration (MEMORY_WIDTH = 8).
    localparam int C_DEF_MEMORY_WIDTH = 8;
    localparam int PTR_W              = ptr_w(C_DEF_MEMORY_WIDTH);

    typedef logic [PTR_W-1:0] fl_ptr_t;

endpackage

`default_nettype wire

// File: rtl/tboom_freelist_mem.sv
// ============================================================================
// Module : tboom_freelist_mem
// Brief  : 2-read / 2-write register array with registered read ports.
//          Reads return the array contents from before the edge, so a write
//          in the same cycle is never visible to a coincident read.
//          A read port whose enable is low holds its last value.
// Ports  : clk, rst           - clock, synchronous active-high reset
//          i_wr{0,1}_en/addr/data - write ports
//          i_rd{0,1}_en/addr  - read requests
//          o_rd{0,1}_data     - registered read data (reset to 0)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tboom_freelist_mem #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_WIDTH = 8,
    parameter int IDX_W        = $clog2(MEMORY_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr0_en,
    input  logic [IDX_W-1:0]      i_wr0_addr,
    input  logic [DATA_WIDTH-1:0] i_wr0_data,
    input  logic                  i_wr1_en,
    input  logic [IDX_W-1:0]      i_wr1_addr,
    input  logic [DATA_WIDTH-1:0] i_wr1_data,
    input  logic                  i_rd0_en,
    input  logic [IDX_W-1:0]      i_rd0_addr,
    input  logic                  i_rd1_en,
    input  logic [IDX_W-1:0]      i_rd1_addr,
    output logic [DATA_WIDTH-1:0] o_rd0_data,
    output logic [DATA_WIDTH-1:0] o_rd1_data
);

    logic [DATA_WIDTH-1:0] r_mem [MEMORY_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd0_data;
    logic [DATA_WIDTH-1:0] r_rd1_data;

    // Storage carries no reset: contents are don't-care until written.
    // The owner never enables both write ports at the same address.
    always_ff @(posedge clk) begin
        if (i_wr0_en) begin
            r_mem[i_wr0_addr] <= i_wr0_data;
        end
        if (i_wr1_en) begin
            r_mem[i_wr1_addr] <= i_wr1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd0_data <= '0;
            r_rd1_data <= '0;
        end else begin
            if (i_rd0_en) begin
                r_rd0_data <= r_mem[i_rd0_addr];
            end
            if (i_rd1_en) begin
                r_rd1_data <= r_mem[i_rd1_addr];
            end
        end
    end

    assign o_rd0_data = r_rd0_data;
    assign o_rd1_data = r_rd1_data;

endmodule

`default_nettype wire

// File: rtl/tboom_freelist_rmt_buffer.sv
// ============================================================================
// Module : tboom_freelist_rmt_buffer
// Brief  : Circular 2R/2W free-list of physical register tags for TinyBOOM
//          rename. Rename pops up to two tags per cycle, commit pushes up to
//          two freed tags per cycle. A single head checkpoint can be saved
//          and restored on a branch-mispredict flush.
// Ports  : clk, rst                        - clock, sync active-high reset
//          i{0,1}_data_in/write_enable     - push ports
//          i{0,1}_read_enable              - pop requests
//          checkpoint / restore            - save / reload head pointer
//          i{0,1}_data_out                 - registered pop data
//          full / one_remaining / empty    - occupancy (combinational)
//          invalid_read / invalid_write    - registered rejected-request flags
// Config : `define TBOOM_FL_STICKY_ERR_EN makes invalid_read/invalid_write
//          sticky until rst; otherwise they are one-cycle pulses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tboom_freelist_rmt_buffer
    import tboom_freelist_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i0_data_in,
    input  logic                  i0_write_enable,
    input  logic                  i0_read_enable,
    input  logic [DATA_WIDTH-1:0] i1_data_in,
    input  logic                  i1_write_enable,
    input  logic                  i1_read_enable,
    input  logic                  checkpoint,
    input  logic                  restore,
    output logic [DATA_WIDTH-1:0] i0_data_out,
    output logic [DATA_WIDTH-1:0] i1_data_out,
    output logic                  full,
    output logic                  one_remaining,
    output logic                  empty,
    output logic                  invalid_read,
    output logic                  invalid_write
);

    localparam int C_PTR_W = ptr_w(MEMORY_WIDTH);
    localparam int C_IDX_W = C_PTR_W - 1;

    localparam logic [C_PTR_W-1:0] C_DEPTH = C_PTR_W'(MEMORY_WIDTH);
    localparam logic [C_PTR_W-1:0] C_ONE   = C_PTR_W'(1);

    // ------------------------------------------------------------------
    // Pointer state
    // ------------------------------------------------------------------
    logic [C_PTR_W-1:0] r_head;
    logic [C_PTR_W-1:0] r_tail;
    logic [C_PTR_W-1:0] r_ckpt_head;
    logic               r_invalid_read;
    logic               r_invalid_write;

    // ------------------------------------------------------------------
    // Occupancy and legality (all on the pre-edge count)
    // ------------------------------------------------------------------
    logic [C_PTR_W-1:0] w_count;
    logic [C_PTR_W-1:0] w_free;
    logic [1:0]         w_nreq;
    logic [1:0]         w_nw;
    logic               w_rd_legal;
    logic               w_wr_legal;
    logic               w_do_read;
    logic               w_do_write;
    logic               w_rd_reject;
    logic               w_wr_reject;

    // Modulo-2N subtraction; the wrap bit makes count == N distinct from 0.
    assign w_count = r_tail - r_head;
    assign w_free  = C_DEPTH - w_count;

    assign w_nreq = {1'b0, i0_read_enable}  + {1'b0, i1_read_enable};
    assign w_nw   = {1'b0, i0_write_enable} + {1'b0, i1_write_enable};

    assign w_rd_legal = (C_PTR_W'(w_nreq) <= w_count);
    assign w_wr_legal = (C_PTR_W'(w_nw)   <= w_free);

    // A restore cycle swallows any read request silently.
    assign w_do_read   = !restore && (w_nreq != 2'd0) &&  w_rd_legal;
    assign w_rd_reject = !restore && (w_nreq != 2'd0) && !w_rd_legal;
    assign w_do_write  = (w_nw != 2'd0) &&  w_wr_legal;
    assign w_wr_reject = (w_nw != 2'd0) && !w_wr_legal;

    // ------------------------------------------------------------------
    // Address steering: a lone enable on either port uses the head/tail
    // slot; with both enabled, port 1 takes the following slot.
    // ------------------------------------------------------------------
    logic [C_IDX_W-1:0] w_head_idx;
    logic [C_IDX_W-1:0] w_tail_idx;
    logic [C_IDX_W-1:0] w_rd1_addr;
    logic [C_IDX_W-1:0] w_wr1_addr;
    logic               w_rd_both;
    logic               w_wr_both;

    assign w_head_idx = r_head[C_IDX_W-1:0];
    assign w_tail_idx = r_tail[C_IDX_W-1:0];
    assign w_rd_both  = i0_read_enable  && i1_read_enable;
    assign w_wr_both  = i0_write_enable && i1_write_enable;
    assign w_rd1_addr = w_rd_both ? (w_head_idx + C_IDX_W'(1)) : w_head_idx;
    assign w_wr1_addr = w_wr_both ? (w_tail_idx + C_IDX_W'(1)) : w_tail_idx;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    tboom_freelist_mem #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEMORY_WIDTH (MEMORY_WIDTH),
        .IDX_W        (C_IDX_W)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .i_wr0_en   (w_do_write && i0_write_enable),
        .i_wr0_addr (w_tail_idx),
        .i_wr0_data (i0_data_in),
        .i_wr1_en   (w_do_write && i1_write_enable),
        .i_wr1_addr (w_wr1_addr),
        .i_wr1_data (i1_data_in),
        .i_rd0_en   (w_do_read && i0_read_enable),
        .i_rd0_addr (w_head_idx),
        .i_rd1_en   (w_do_read && i1_read_enable),
        .i_rd1_addr (w_rd1_addr),
        .o_rd0_data (i0_data_out),
        .o_rd1_data (i1_data_out)
    );

    // ------------------------------------------------------------------
    // Pointer / flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_ckpt_head     <= '0;
            r_invalid_read  <= 1'b0;
            r_invalid_write <= 1'b0;
        end else begin
            if (restore) begin
                r_head <= r_ckpt_head;
            end else if (w_do_read) begin
                r_head <= r_head + C_PTR_W'(w_nreq);
            end

            // Restore wins over a coincident checkpoint; the saved value is
            // the head as it stood before this cycle's pops.
            if (checkpoint && !restore) begin
                r_ckpt_head <= r_head;
            end

            if (w_do_write) begin
                r_tail <= r_tail + C_PTR_W'(w_nw);
            end

`ifdef TBOOM_FL_STICKY_ERR_EN
            r_invalid_read  <= r_invalid_read  | w_rd_reject;
            r_invalid_write <= r_invalid_write | w_wr_reject;
`else
            r_invalid_read  <= w_rd_reject;
            r_invalid_write <= w_wr_reject;
`endif
        end
    end

    assign full          = (w_count == C_DEPTH);
    assign one_remaining = (w_count == C_ONE);
    assign empty         = (w_count == '0);
    assign invalid_read  = r_invalid_read;
    assign invalid_write = r_invalid_write;

endmodule

`default_nettype wire

// File: tb/tb_tboom_freelist_rmt_buffer.sv
// ============================================================================
// Module : tb_tboom_freelist_rmt_buffer
// Brief  : Self-checking bench for tboom_freelist_rmt_buffer. A reference
//          model keeps the full push history with absolute head/tail
//          indices; each applied cycle pushes the expected post-edge outputs
//          into a scoreboard, popped and compared after the edge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tboom_freelist_rmt_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] i0_data_in = '0;
    logic          i0_write_enable = 1'b0;
    logic          i0_read_enable = 1'b0;
    logic [DW-1:0] i1_data_in = '0;
    logic          i1_write_enable = 1'b0;
    logic          i1_read_enable = 1'b0;
    logic          checkpoint = 1'b0;
    logic          restore = 1'b0;
    logic [DW-1:0] i0_data_out;
    logic [DW-1:0] i1_data_out;
    logic          full;
    logic          one_remaining;
    logic          empty;
    logic          invalid_read;
    logic          invalid_write;

    always #5 clk = ~clk;

    tboom_freelist_rmt_buffer #(
        .DATA_WIDTH   (DW),
        .MEMORY_WIDTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i0_data_in      (i0_data_in),
        .i0_write_enable (i0_write_enable),
        .i0_read_enable  (i0_read_enable),
        .i1_data_in      (i1_data_in),
        .i1_write_enable (i1_write_enable),
        .i1_read_enable  (i1_read_enable),
        .checkpoint      (checkpoint),
        .restore         (restore),
        .i0_data_out     (i0_data_out),
        .i1_data_out     (i1_data_out),
        .full            (full),
        .one_remaining   (one_remaining),
        .empty           (empty),
        .invalid_read    (invalid_read),
        .invalid_write   (invalid_write)
    );

    typedef struct {
        logic [DW-1:0] o0;
        logic [DW-1:0] o1;
        logic          full;
        logic          one;
        logic          empty;
        logic          ir;
        logic          iw;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [DW-1:0] hist[$];
    int            m_head = 0;
    int            m_ckpt = 0;
    logic [DW-1:0] m_o0 = '0;
    logic [DW-1:0] m_o1 = '0;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] next_val = 32'd1000;

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int m_count();
        return hist.size() - m_head;
    endfunction

    // One clock cycle of stimulus; model predicts the post-edge outputs.
    task automatic apply(input logic r, input logic re0, input logic re1,
                         input logic we0, input logic we1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic ck, input logic rs);
        exp_t e;
        exp_t g;
        int   cnt;
        int   nreq;
        int   nw;
        int   head_pre;
        @(negedge clk);
        rst = r; i0_read_enable = re0; i1_read_enable = re1;
        i0_write_enable = we0; i1_write_enable = we1;
        i0_data_in = d0; i1_data_in = d1; checkpoint = ck; restore = rs;

        e.ir = 1'b0;
        e.iw = 1'b0;
        if (r) begin
            hist.delete();
            m_head = 0; m_ckpt = 0; m_o0 = '0; m_o1 = '0;
        end else begin
            cnt      = m_count();
            nreq     = int'(re0) + int'(re1);
            nw       = int'(we0) + int'(we1);
            head_pre = m_head;
            if (rs) begin
                m_head = m_ckpt;
            end else if (nreq > 0) begin
                if (nreq <= cnt) begin
                    if (re0 && re1) begin
                        m_o0 = hist[m_head]; m_o1 = hist[m_head + 1];
                    end else if (re0) begin
                        m_o0 = hist[m_head];
                    end else begin
                        m_o1 = hist[m_head];
                    end
                    m_head += nreq;
                end else begin
                    e.ir = 1'b1;
                end
            end
            if (ck && !rs) m_ckpt = head_pre;
            if (nw > 0) begin
                if (nw <= DEPTH - cnt) begin
                    if (we0) hist.push_back(d0);
                    if (we1) hist.push_back(d1);
                end else begin
                    e.iw = 1'b1;
                end
            end
        end
        e.o0    = m_o0;
        e.o1    = m_o1;
        e.full  = (m_count() == DEPTH);
        e.one   = (m_count() == 1);
        e.empty = (m_count() == 0);
        sb.push_back(e);

        @(posedge clk);
        #1;
        g = sb.pop_front();
        check_eq("i0_data_out",   i0_data_out,   g.o0);
        check_eq("i1_data_out",   i1_data_out,   g.o1);
        check_eq("full",          full,          g.full);
        check_eq("one_remaining", one_remaining, g.one);
        check_eq("empty",         empty,         g.empty);
        check_eq("invalid_read",  invalid_read,  g.ir);
        check_eq("invalid_write", invalid_write, g.iw);
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && m_count() > 0; k++) begin
            apply(0, 1, 0, 0, 0, '0, '0, 0, 0);
        end
    endtask

    initial begin
        // Reset state
        apply(1, 0, 0, 0, 0, '0, '0, 0, 0);
        apply(1, 0, 0, 0, 0, '0, '0, 0, 0);
        idle();

        // Fill with 100..107 using dual writes
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 0, 1, 1, DW'(100 + 2 * k), DW'(101 + 2 * k), 0, 0);
        end

        // Checkpoint, dual read, restore, dual read again
        apply(0, 0, 0, 0, 0, '0, '0, 1, 0);
        apply(0, 1, 1, 0, 0, '0, '0, 0, 0);
        apply(0, 0, 0, 0, 0, '0, '0, 0, 1);
        apply(0, 1, 1, 0, 0, '0, '0, 0, 0);

        // Single reads down to one entry, then illegal dual, then last pop
        for (int k = 0; k < DEPTH && m_count() > 1; k++) begin
            apply(0, 1, 0, 0, 0, '0, '0, 0, 0);
        end
        apply(0, 1, 1, 0, 0, '0, '0, 0, 0);
        apply(0, 1, 0, 0, 0, '0, '0, 0, 0);
        idle();

        // Overfill: 4 dual + 1 single (rejected), then dual with 1 slot free
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 0, 1, 1, DW'(200 + 2 * k), DW'(201 + 2 * k), 0, 0);
        end
        apply(0, 0, 0, 1, 0, DW'(208), '0, 0, 0);
        apply(0, 0, 1, 0, 0, '0, '0, 0, 0);
        apply(0, 0, 0, 1, 1, DW'(300), DW'(301), 0, 0);
        apply(0, 0, 0, 0, 1, DW'(302), '0, 0, 0);
        drain();

        // Restore with coincident read and write: write lands, read ignored
        apply(0, 0, 0, 1, 1, DW'(400), DW'(401), 1, 0);
        apply(0, 1, 0, 1, 0, '0, DW'(0), 0, 0);
        apply(0, 1, 1, 1, 0, DW'(402), '0, 1, 1);
        drain();

        // Wrap: random interleaving over several passes of the ring
        for (int k = 0; k < 80; k++) begin
            logic re0, re1, we0, we1;
            re0 = 1'($urandom_range(0, 1));
            re1 = 1'($urandom_range(0, 1));
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            apply(0, re0, re1, we0, we1, next_val, next_val + 1, 0, 0);
            next_val += 2;
        end
        drain();

        // Read + write at count 0: read rejected, write accepted
        apply(0, 1, 0, 1, 0, DW'(555), '0, 0, 0);
        apply(0, 0, 1, 0, 0, '0, '0, 0, 0);

        // Mid-operation reset
        apply(0, 0, 0, 1, 1, DW'(600), DW'(601), 0, 0);
        apply(1, 1, 0, 1, 0, DW'(602), '0, 0, 0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
